display_bcd_converter: RTL

Sequential binary-to-decimal display stage sitting directly downstream of the processor's register-file display tap (the 32-bit value selected by `user_number`). On a `start` request it captures a 32-bit binary word, converts it to BCD with an iterative shift-and-add-3 (double-dabble) engine, and drives four active-low seven-segment digit buses. Values above 9999 raise `overflow` and show dashes. It replaces a purely combinational divider chain with a small multicycle engine, trading latency for area.

---
 rtl/display_bcd_converter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/display_bcd_converter.sv
// display_bcd_converter
//
// Multicycle binary-to-decimal display stage. A start request captures a
// WIDTH-bit unsigned word. An iterative shift-and-add-3 (double-dabble)
// engine converts it to BCD, one bit per cycle. The lowest four BCD digits
// then drive four active-low seven-segment buses. Values above 9999 raise
// overflow and show dashes.
//
// Parameters:
//   WIDTH       width of the binary input word (one shift cycle per bit)
//   BCD_DIGITS  internal BCD digit count; 10**BCD_DIGITS must exceed 2**WIDTH
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   binary     in   value to convert, sampled only on the accepting edge
//   start      in   conversion request, level-sampled, accepted only in IDLE
//   busy       out  high while the engine is shifting
//   done       out  one-cycle pulse when new digits become valid
//   overflow   out  last converted value exceeded 9999
//   ones, tens, hundreds, thousands
//              out  active-low segments, bit0 = a ... bit6 = g
module display_bcd_converter #(
    parameter int WIDTH      = 32,
    parameter int BCD_DIGITS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] binary,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [6:0]       ones,
    output logic [6:0]       tens,
    output logic [6:0]       hundreds,
    output logic [6:0]       thousands
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Counter value at which the final (WIDTH-th) shift takes place.
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_q;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+WIDTH-1:0] joined;
    logic                   upper_nonzero;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One double-dabble step. Every nibble >= 5 gets +3 first. Then the
    // joined {bcd, shift} word moves left one place, so the binary MSB
    // enters BCD bit 0.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path can hold a stale value and infer a latch.
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        joined = {bcd_adj, shift_q} << 1;
    end

    // Any nonzero digit above the thousands place means the value is > 9999.
    assign upper_nonzero = |bcd_q[BCD_W-1:16];

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            ones      <= SEG_BLANK;
            tens      <= SEG_BLANK;
            hundreds  <= SEG_BLANK;
            thousands <= SEG_BLANK;
        end else begin
            // NOTE: state registers use non-blocking assignments so that every register samples pre-edge values regardless of statement order.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shift_q <= binary;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    bcd_q   <= joined[BCD_W+WIDTH-1:WIDTH];
                    shift_q <= joined[WIDTH-1:0];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_SHIFT) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    overflow <= upper_nonzero;
                    if (upper_nonzero) begin
                        ones      <= SEG_DASH;
                        tens      <= SEG_DASH;
                        hundreds  <= SEG_DASH;
                        thousands <= SEG_DASH;
                    end else begin
                        ones      <= seg_encode(bcd_q[3:0]);
                        tens      <= seg_encode(bcd_q[7:4]);
                        hundreds  <= seg_encode(bcd_q[11:8]);
                        thousands <= seg_encode(bcd_q[15:12]);
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
